// File: rtl/clk_div_ctrl_pkg.sv
// Shared types for the clock-divider configuration controller.
package clk_div_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STEP   = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

endpackage

// File: rtl/clk_div_ctrl.sv
// Slews the divider's divisor toward a requested target in bounded, settled steps.
// Optional request clamping to [DIV_MIN, DIV_MAX] is enabled by CLK_DIV_CTRL_CLAMP_EN.
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int DIV_WIDTH     = 4,
    parameter int STEP          = 1,
    parameter int SETTLE_CYCLES = 8,
    parameter int RESET_DIV     = 0,
    parameter int DIV_MIN       = 0,
    parameter int DIV_MAX       = 2**DIV_WIDTH - 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DIV_WIDTH-1:0] req_div_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    output logic [DIV_WIDTH-1:0] div_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 clamp_o
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [DIV_WIDTH-1:0] RESET_VAL   = DIV_WIDTH'(RESET_DIV);
    localparam logic [CNT_W-1:0]     SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_ONE     = CNT_W'(1);
    localparam logic [DIV_WIDTH:0]   STEP_EXT    = (DIV_WIDTH + 1)'(STEP);

    if (STEP < 1) begin : g_bad_step
        $error("clk_div_ctrl: STEP must be at least 1");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("clk_div_ctrl: SETTLE_CYCLES must be at least 1");
    end
    if (RESET_DIV < 0 || RESET_DIV > 2**DIV_WIDTH - 1) begin : g_bad_reset
        $error("clk_div_ctrl: RESET_DIV does not fit in DIV_WIDTH");
    end
    if (DIV_MIN > DIV_MAX) begin : g_bad_bounds
        $error("clk_div_ctrl: DIV_MAX must be at least DIV_MIN");
    end

    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] target_q, target_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic                 clamp_q, clamp_d;

    logic [DIV_WIDTH-1:0] req_target;
    logic                 req_clamped;

`ifdef CLK_DIV_CTRL_CLAMP_EN
    localparam logic [DIV_WIDTH-1:0] MIN_VAL = DIV_WIDTH'(DIV_MIN);
    localparam logic [DIV_WIDTH-1:0] MAX_VAL = DIV_WIDTH'(DIV_MAX);

    always_comb begin
        req_target = req_div_i;
        if (req_div_i < MIN_VAL) begin
            req_target = MIN_VAL;
        end else if (req_div_i > MAX_VAL) begin
            req_target = MAX_VAL;
        end
    end
    assign req_clamped = (req_target != req_div_i);
`else
    assign req_target  = req_div_i;
    assign req_clamped = 1'b0;
`endif

    // One step toward target: extended by a bit so neither direction can wrap.
    logic [DIV_WIDTH:0]   div_ext, tgt_ext, diff, stepped;
    logic                 step_up;
    logic [DIV_WIDTH-1:0] step_next;

    always_comb begin
        div_ext   = {1'b0, div_q};
        tgt_ext   = {1'b0, target_q};
        step_up   = (target_q > div_q);
        diff      = step_up ? (tgt_ext - div_ext) : (div_ext - tgt_ext);
        stepped   = step_up ? (div_ext + STEP_EXT) : (div_ext - STEP_EXT);
        step_next = stepped[DIV_WIDTH-1:0];
        if (32'(diff) <= 32'(STEP) || stepped[DIV_WIDTH]) begin
            step_next = target_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        clamp_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    target_d = req_target;
                    clamp_d  = req_clamped;
                    if (req_target == div_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_STEP;
                    end
                end
            end
            ST_STEP: begin
                div_d   = step_next;
                cnt_d   = SETTLE_LOAD;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                // Counter reaching one marks the last of the settle cycles.
                if (cnt_q == CNT_ONE) begin
                    cnt_d = '0;
                    if (div_q != target_q) begin
                        state_d = ST_STEP;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            div_q    <= RESET_VAL;
            target_q <= RESET_VAL;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            clamp_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            clamp_q  <= clamp_d;
        end
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign div_o       = div_q;
    assign done_o      = done_q;
    assign clamp_o     = clamp_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: two instances (STEP=1 and STEP=4), model-predicted event queues.
module tb_clk_div_ctrl;

    localparam int W  = 4;
    localparam int SC = 8;
`ifdef CLK_DIV_CTRL_CLAMP_EN
    localparam bit CLAMP_ON = 1'b1;
    localparam int RST1     = 2;
`else
    localparam bit CLAMP_ON = 1'b0;
    localparam int RST1     = 0;
`endif

    typedef struct {
        int edge_n;
        int val;
    } ev_t;

    logic         clk = 1'b0;
    logic         rst_n     [2];
    logic [W-1:0] req_div   [2];
    logic         req_valid [2];
    logic         req_ready [2];
    logic [W-1:0] div_w     [2];
    logic         busy      [2];
    logic         done      [2];
    logic         clamp     [2];

    int  edge_cnt = 0;
    bit  rst_edge [2];
    ev_t div_q    [2][$];
    ev_t done_q   [2][$];
    int  clamp_q  [2][$];
    int  model_div [2];
    int  idle_from [2];
    int  busy_lo   [2];
    int  busy_hi   [2];
    int  prev_div  [2];
    int  checks = 0;
    int  errors = 0;

    function automatic int step_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction
    function automatic int rst_of(input int i);
        return (i == 0) ? 0 : RST1;
    endfunction
    function automatic int min_of(input int i);
        return (i == 0) ? 0 : 2;
    endfunction
    function automatic int max_of(input int i);
        return (i == 0) ? 15 : 12;
    endfunction

    always #5 clk = ~clk;

    clk_div_ctrl #(
        .DIV_WIDTH(W), .STEP(1), .SETTLE_CYCLES(SC), .RESET_DIV(0),
        .DIV_MIN(0), .DIV_MAX(15)
    ) dut0 (
        .clk_i(clk), .rst_ni(rst_n[0]), .req_div_i(req_div[0]), .req_valid_i(req_valid[0]),
        .req_ready_o(req_ready[0]), .div_o(div_w[0]), .busy_o(busy[0]),
        .done_o(done[0]), .clamp_o(clamp[0])
    );

    clk_div_ctrl #(
        .DIV_WIDTH(W), .STEP(4), .SETTLE_CYCLES(SC), .RESET_DIV(RST1),
        .DIV_MIN(2), .DIV_MAX(12)
    ) dut1 (
        .clk_i(clk), .rst_ni(rst_n[1]), .req_div_i(req_div[1]), .req_valid_i(req_valid[1]),
        .req_ready_o(req_ready[1]), .div_o(div_w[1]), .busy_o(busy[1]),
        .done_o(done[1]), .clamp_o(clamp[1])
    );

    task automatic chk(input int i, input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL inst%0d %s @edge %0d: got %0d expected %0d", i, name, edge_cnt, act, exp);
        end
    endtask

    initial begin : edge_counter
        forever begin
            @(posedge clk);
            edge_cnt++;
            rst_edge[0] = !rst_n[0];
            rst_edge[1] = !rst_n[1];
        end
    end

    // Monitor: compares whatever the DUT presents against the queued predictions.
    initial begin : monitor
        ev_t e;
        int  ce;
        bit  exp_busy;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst_edge[i]) begin
                    chk(i, "rst_div", int'(div_w[i]), rst_of(i));
                    chk(i, "rst_ready", int'(req_ready[i]), 1);
                    chk(i, "rst_busy", int'(busy[i]), 0);
                    chk(i, "rst_done", int'(done[i]), 0);
                    chk(i, "rst_clamp", int'(clamp[i]), 0);
                    prev_div[i] = int'(div_w[i]);
                end else begin
                    exp_busy = (edge_cnt >= busy_lo[i]) && (edge_cnt <= busy_hi[i]);
                    chk(i, "busy", int'(busy[i]), int'(exp_busy));
                    chk(i, "ready", int'(req_ready[i]), int'(!exp_busy));
                    if (int'(div_w[i]) != prev_div[i]) begin
                        if (div_q[i].size() == 0) begin
                            chk(i, "unexpected_div_change", int'(div_w[i]), prev_div[i]);
                        end else begin
                            e = div_q[i].pop_front();
                            chk(i, "div_edge", edge_cnt, e.edge_n);
                            chk(i, "div_value", int'(div_w[i]), e.val);
                        end
                    end
                    prev_div[i] = int'(div_w[i]);
                    if (done[i]) begin
                        if (done_q[i].size() == 0) begin
                            chk(i, "unexpected_done", int'(done[i]), 0);
                        end else begin
                            e = done_q[i].pop_front();
                            chk(i, "done_edge", edge_cnt, e.edge_n);
                            chk(i, "done_final_div", int'(div_w[i]), e.val);
                        end
                    end
                    if (clamp[i]) begin
                        if (clamp_q[i].size() == 0) begin
                            chk(i, "unexpected_clamp", int'(clamp[i]), 0);
                        end else begin
                            ce = clamp_q[i].pop_front();
                            chk(i, "clamp_edge", edge_cnt, ce);
                        end
                    end
                    while (div_q[i].size() > 0 && div_q[i][0].edge_n < edge_cnt) begin
                        e = div_q[i].pop_front();
                        chk(i, "missed_div_change", edge_cnt, e.edge_n);
                    end
                    while (done_q[i].size() > 0 && done_q[i][0].edge_n < edge_cnt) begin
                        e = done_q[i].pop_front();
                        chk(i, "missed_done", edge_cnt, e.edge_n);
                    end
                    while (clamp_q[i].size() > 0 && clamp_q[i][0] < edge_cnt) begin
                        ce = clamp_q[i].pop_front();
                        chk(i, "missed_clamp", edge_cnt, ce);
                    end
                end
            end
        end
    end

    // Present a request; it is accepted on the first edge the model says the block is idle.
    task automatic issue(input int i, input int req);
        int n = 0;
        int a, tgt, d, k, sgn, mv;
        ev_t e;
        req_div[i]   = W'(req);
        req_valid[i] = 1'b1;
        while (edge_cnt < idle_from[i]) begin
            @(negedge clk);
            n++;
            if (n > 1000) begin
                chk(i, "accept_timeout", n, 0);
                req_valid[i] = 1'b0;
                return;
            end
        end
        a   = edge_cnt + 1;
        tgt = req;
        if (CLAMP_ON) begin
            if (tgt < min_of(i)) tgt = min_of(i);
            if (tgt > max_of(i)) tgt = max_of(i);
            if (tgt != req) clamp_q[i].push_back(a);
        end
        sgn = (tgt >= model_div[i]) ? 1 : -1;
        d   = (tgt >= model_div[i]) ? tgt - model_div[i] : model_div[i] - tgt;
        k   = (d + step_of(i) - 1) / step_of(i);
        for (int j = 1; j <= k; j++) begin
            mv       = (j * step_of(i) < d) ? j * step_of(i) : d;
            e.edge_n = a + 1 + (j - 1) * (SC + 1);
            e.val    = model_div[i] + sgn * mv;
            div_q[i].push_back(e);
        end
        e.edge_n = a + k * (SC + 1);
        e.val    = tgt;
        done_q[i].push_back(e);
        if (k > 0) begin
            busy_lo[i] = a;
            busy_hi[i] = a + k * (SC + 1) - 1;
        end else begin
            busy_lo[i] = 0;
            busy_hi[i] = -1;
        end
        idle_from[i] = a + k * (SC + 1);
        model_div[i] = tgt;
        $display("inst%0d req %0d accepted @edge %0d target %0d steps %0d", i, req, a, tgt, k);
        @(negedge clk);
        req_valid[i] = 1'b0;
    endtask

    task automatic do_reset(input int i, input int n);
        rst_n[i]     = 1'b0;
        req_valid[i] = 1'b0;
        @(posedge clk);
        #1;
        div_q[i].delete();
        done_q[i].delete();
        clamp_q[i].delete();
        busy_lo[i] = 0;
        busy_hi[i] = -1;
        repeat (n) @(negedge clk);
        rst_n[i]     = 1'b1;
        model_div[i] = rst_of(i);
        idle_from[i] = edge_cnt;
        $display("inst%0d reset released @edge %0d", i, edge_cnt);
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        while (edge_cnt < idle_from[i] + 1) begin
            @(negedge clk);
            n++;
            if (n > 1000) begin
                chk(i, "idle_timeout", n, 0);
                return;
            end
        end
    endtask

    task automatic random_phase(input int i, input int count);
        for (int r = 0; r < count; r++) begin
            case ($urandom_range(0, 3))
                0: ;
                1: repeat ($urandom_range(1, 12)) @(negedge clk);
                default: wait_idle(i);
            endcase
            issue(i, int'($urandom_range(0, 15)));
        end
    endtask

    initial begin : stimulus
        for (int i = 0; i < 2; i++) begin
            rst_n[i]     = 1'b0;
            req_valid[i] = 1'b0;
            req_div[i]   = '0;
            busy_lo[i]   = 0;
            busy_hi[i]   = -1;
            model_div[i] = rst_of(i);
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            rst_n[i]     = 1'b1;
            idle_from[i] = edge_cnt;
        end

        issue(0, 3);
        issue(0, 3);
        issue(0, 5);
        repeat (4) @(negedge clk);
        issue(0, 1);
        issue(0, 12);
        repeat (15) @(negedge clk);
        do_reset(0, 3);
        issue(0, 2);
        random_phase(0, 25);
        wait_idle(0);

        issue(1, 15);
        issue(1, 12);
        issue(1, 1);
        issue(1, 14);
        random_phase(1, 25);
        wait_idle(1);

        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk(i, "div_events_left", div_q[i].size(), 0);
            chk(i, "done_events_left", done_q[i].size(), 0);
            chk(i, "clamp_events_left", clamp_q[i].size(), 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: bench did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
